// File: rtl/deck_pkg.sv
// deck_pkg: shared constants, FSM state type and LFSR helper for the deck shuffle sequencer.
// Contents: DECK_SIZE_DEF (default deck size), IDX_W (RAM address / card code width),
// LFSR_TAPS (x^6+x^5+1), LFSR_ZERO_SUB (substitute for an all-zero seed),
// state_t (sequencer states), lfsr_next() (one Fibonacci LFSR step).
package deck_pkg;

    localparam int          DECK_SIZE_DEF = 52;
    localparam int          IDX_W         = 6;
    localparam logic [5:0]  LFSR_TAPS     = 6'b110000;
    localparam logic [5:0]  LFSR_ZERO_SUB = 6'b000001;

    typedef enum logic [3:0] {
        IDLE,
        INIT,
        PICK,
        RD_I,
        RD_J,
        CAP_J,
        WR_I,
        WR_J,
        FIN,
        READY,
        DRAW
    } state_t;

    // Feedback bit is the XOR of the tapped bits, shifted in at the LSB.
    function automatic logic [5:0] lfsr_next(input logic [5:0] q);
        return {q[4:0], ^(q & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/deck_shuffle_ctrl_if.sv
// deck_shuffle_ctrl_if: bundle of the sequencer's game-controller and deck-RAM signals.
// Signals: start/seed (shuffle request), busy/done (shuffle status),
// mem_addr/mem_we/mem_wdata/mem_rdata (single-port deck RAM, 1-cycle read latency),
// draw_req/draw_valid/draw_card/deck_empty (card draw handshake).
// Modports: slave = the sequencer, master = the environment (controller + RAM).
interface deck_shuffle_ctrl_if;
    import deck_pkg::*;

    logic             start;
    logic [5:0]       seed;
    logic             busy;
    logic             done;
    logic [IDX_W-1:0] mem_addr;
    logic             mem_we;
    logic [IDX_W-1:0] mem_wdata;
    logic [IDX_W-1:0] mem_rdata;
    logic             draw_req;
    logic             draw_valid;
    logic [IDX_W-1:0] draw_card;
    logic             deck_empty;

    modport slave (
        input  start, seed, mem_rdata, draw_req,
        output busy, done, mem_addr, mem_we, mem_wdata, draw_valid, draw_card, deck_empty
    );

    modport master (
        output start, seed, mem_rdata, draw_req,
        input  busy, done, mem_addr, mem_we, mem_wdata, draw_valid, draw_card, deck_empty
    );

endinterface

// File: rtl/deck_lfsr.sv
// deck_lfsr: 6-bit Fibonacci LFSR (x^6+x^5+1) used to pick swap partners.
// Ports: clk, rst (sync, active-low), load/load_val (reload; zero maps to 6'b000001),
// step (advance one state), q (current state, never zero).
module deck_lfsr
    import deck_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [5:0] load_val,
    input  logic       step,
    output logic [5:0] q
);

    always_ff @(posedge clk) begin
        if (!rst)
            q <= LFSR_ZERO_SUB;
        else if (load)
            q <= (load_val == 6'd0) ? LFSR_ZERO_SUB : load_val;
        else if (step)
            q <= lfsr_next(q);
    end

endmodule

// File: rtl/deck_shuffle_ctrl.sv
// deck_shuffle_ctrl: owns the deck RAM; writes an ordered deck, Fisher-Yates shuffles it in
// place, then serves card draws from address 0 upward.
// Ports: clk, rst (sync, active-low), bus (deck_shuffle_ctrl_if.slave: start/seed, busy/done,
// deck RAM port, draw_req/draw_valid/draw_card/deck_empty).
// Build option: AUTO_RESHUFFLE_EN makes a draw on an empty deck trigger a reshuffle from the
// current LFSR state and serve that draw once the shuffle finishes.
module deck_shuffle_ctrl
    import deck_pkg::*;
#(
    parameter int DECK_SIZE = DECK_SIZE_DEF
) (
    input  logic               clk,
    input  logic               rst,
    deck_shuffle_ctrl_if.slave bus
);

`ifdef AUTO_RESHUFFLE_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    localparam logic [IDX_W-1:0] LAST = IDX_W'(DECK_SIZE - 1);
    localparam logic [IDX_W-1:0] SIZE = IDX_W'(DECK_SIZE);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] k_q, k_d, i_q, i_d, j_q, j_d, p_q, p_d, a_q, a_d, b_q, b_d;
    logic [IDX_W-1:0] addr_q, addr_d, wdata_q, wdata_d, card_q, card_d;
    logic             busy_q, busy_d, done_q, done_d, we_q, we_d;
    logic             dv_q, dv_d, empty_q, empty_d;
    logic             rd_q, rd_d, auto_q, auto_d;
    logic             lfsr_load, lfsr_step;
    logic [5:0]       lfsr_q;
    logic [IDX_W-1:0] r;

    // LFSR never holds zero, so the candidate index spans 0..62.
    assign r = lfsr_q - 6'd1;

    deck_lfsr u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .load     (lfsr_load),
        .load_val (bus.seed),
        .step     (lfsr_step),
        .q        (lfsr_q)
    );

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        i_d       = i_q;
        j_d       = j_q;
        p_d       = p_q;
        a_d       = a_q;
        b_d       = b_q;
        empty_d   = empty_q;
        auto_d    = auto_q;
        rd_d      = 1'b0;
        lfsr_load = 1'b0;
        lfsr_step = 1'b0;
        if ((state_q == IDLE || state_q == READY) && bus.start) begin
            state_d   = INIT;
            k_d       = '0;
            lfsr_load = 1'b1;
            empty_d   = 1'b1;
            auto_d    = 1'b0;
        end else begin
            case (state_q)
                INIT: begin
                    if (k_q == LAST) begin
                        state_d = PICK;
                        i_d     = LAST;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
                PICK: begin
                    // Rejection sampling: step every cycle, accept the first candidate <= i.
                    lfsr_step = 1'b1;
                    if (r <= i_q) begin
                        j_d     = r;
                        state_d = RD_I;
                    end
                end
                RD_I:  state_d = RD_J;
                RD_J: begin
                    a_d     = bus.mem_rdata;
                    state_d = CAP_J;
                end
                CAP_J: begin
                    b_d     = bus.mem_rdata;
                    state_d = WR_I;
                end
                WR_I:  state_d = WR_J;
                WR_J: begin
                    if (i_q == IDX_W'(1)) begin
                        state_d = FIN;
                    end else begin
                        i_d     = i_q - 1'b1;
                        state_d = PICK;
                    end
                end
                FIN: begin
                    // A deferred auto-reshuffle draw reads address 0, which FIN already drives.
                    state_d = READY;
                    p_d     = auto_q ? IDX_W'(1) : '0;
                    rd_d    = auto_q;
                    empty_d = 1'b0;
                    auto_d  = 1'b0;
                end
                READY: begin
                    if (bus.draw_req && p_q < SIZE) begin
                        state_d = DRAW;
                    end else if (AUTO && bus.draw_req && empty_q) begin
                        state_d = INIT;
                        k_d     = '0;
                        auto_d  = 1'b1;
                    end
                end
                DRAW: begin
                    // Read data lands one cycle later; rd_q captures it into draw_card.
                    p_d     = p_q + 1'b1;
                    empty_d = (p_q + 1'b1) == SIZE;
                    rd_d    = 1'b1;
                    state_d = READY;
                end
                default: state_d = IDLE;
            endcase
        end
        // Outputs are registered from the next state so they line up with the state they serve.
        busy_d  = state_d inside {INIT, PICK, RD_I, RD_J, CAP_J, WR_I, WR_J, FIN};
        done_d  = state_d == FIN;
        we_d    = state_d inside {INIT, WR_I, WR_J};
        addr_d  = (state_d == INIT)              ? k_d :
                  (state_d inside {RD_I, WR_I}) ? i_d :
                  (state_d inside {RD_J, WR_J}) ? j_d :
                  (state_d == DRAW)              ? p_d :
                  (state_d == FIN)               ? '0  : addr_q;
        wdata_d = (state_d == INIT) ? k_d :
                  (state_d == WR_I) ? b_d :
                  (state_d == WR_J) ? a_d : wdata_q;
        dv_d    = rd_q;
        card_d  = rd_q ? bus.mem_rdata : card_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            i_q     <= '0;
            j_q     <= '0;
            p_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            card_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            we_q    <= 1'b0;
            dv_q    <= 1'b0;
            empty_q <= 1'b1;
            rd_q    <= 1'b0;
            auto_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            i_q     <= i_d;
            j_q     <= j_d;
            p_q     <= p_d;
            a_q     <= a_d;
            b_q     <= b_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            card_q  <= card_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            we_q    <= we_d;
            dv_q    <= dv_d;
            empty_q <= empty_d;
            rd_q    <= rd_d;
            auto_q  <= auto_d;
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_we     = we_q;
    assign bus.mem_wdata  = wdata_q;
    assign bus.draw_valid = dv_q;
    assign bus.draw_card  = card_q;
    assign bus.deck_empty = empty_q;

endmodule

// File: tb/tb_deck_shuffle_ctrl.sv
// tb_deck_shuffle_ctrl: self-checking bench for deck_shuffle_ctrl with a behavioural deck RAM
// and a Fisher-Yates reference model driven by the same LFSR polynomial.
module tb_deck_shuffle_ctrl;

    localparam int DS = 52;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    deck_shuffle_ctrl_if bus();

    deck_shuffle_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [5:0] ram [0:63];
    logic [5:0] saved [0:63];
    logic [5:0] wa [$];
    logic [5:0] wd [$];
    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int dv_cnt = 0;
    int exp_perm [0:63];
    int exp_cyc;

    always @(posedge clk) begin
        if (bus.mem_we === 1'b1) begin
            ram[bus.mem_addr] <= bus.mem_wdata;
            wa.push_back(bus.mem_addr);
            wd.push_back(bus.mem_wdata);
        end
        bus.mem_rdata <= ram[bus.mem_addr];
    end

    always @(negedge clk) begin
        if (bus.done === 1'b1) done_cnt++;
        if (bus.draw_valid === 1'b1) dv_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: ordered deck, then for i = DS-1..1 draw candidates lfsr-1 until one is <= i,
    // swap deck[i] with deck[candidate]. Cycle count = DS + sum(picks + 5) + 1.
    task automatic model(input logic [5:0] s);
        logic [5:0] l;
        int r, t;
        l = (s == 6'd0) ? 6'd1 : s;
        exp_cyc = DS + 1;
        for (int k = 0; k < DS; k++) exp_perm[k] = k;
        for (int i = DS - 1; i >= 1; i--) begin
            do begin
                r = int'(l) - 1;
                l = {l[4:0], l[5] ^ l[4]};
                exp_cyc++;
            end while (r > i);
            t = exp_perm[i];
            exp_perm[i] = exp_perm[r];
            exp_perm[r] = t;
            exp_cyc += 5;
        end
    endtask

    // mode 0: plain start; 1: draw_req together with start; 2: start/draw_req pulses while busy.
    task automatic run_shuffle(input logic [5:0] s, input int mode);
        int cyc, wb, d0, v0, mism;
        logic [63:0] seen;
        model(s);
        wb = wa.size();
        d0 = done_cnt;
        v0 = dv_cnt;
        bus.seed = s;
        bus.start = 1'b1;
        bus.draw_req = (mode == 1);
        @(negedge clk);
        bus.start = 1'b0;
        bus.draw_req = 1'b0;
        bus.seed = 6'($urandom);
        chk("busy_rise", bus.busy, 1);
        cyc = 0;
        while (bus.busy === 1'b1 && cyc < 6000) begin
            bus.draw_req = (mode == 2) && (cyc % 97 == 5);
            bus.start = (mode == 2) && (cyc % 97 == 50);
            cyc++;
            @(negedge clk);
        end
        bus.draw_req = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        chk("shuffle_cycles", cyc, exp_cyc);
        chk("done_pulses", done_cnt - d0, 1);
        chk("no_draw_during_shuffle", dv_cnt - v0, 0);
        chk("deck_empty_clear", bus.deck_empty, 0);
        chk("write_count", wa.size() - wb, DS + 2 * (DS - 1));
        mism = 0;
        for (int k = 0; k < DS; k++)
            if (wb + k >= wa.size() || wa[wb + k] !== 6'(k) || wd[wb + k] !== 6'(k)) mism++;
        chk("init_writes", mism, 0);
        mism = 0;
        seen = '0;
        for (int k = 0; k < DS; k++) begin
            if (ram[k] !== 6'(exp_perm[k])) mism++;
            seen[ram[k]] = 1'b1;
        end
        chk("perm_model", mism, 0);
        chk("perm_valid", seen[31:0], 32'hFFFF_FFFF);
        chk("perm_valid_hi", seen[63:32], 32'h000F_FFFF);
    endtask

    task automatic draw_n(input int base, input int n);
        int lat_err = 0;
        int card_err = 0;
        int v0 = dv_cnt;
        for (int d = 0; d < n; d++) begin
            bus.draw_req = 1'b1;
            @(negedge clk);
            bus.draw_req = 1'b0;
            if (bus.draw_valid !== 1'b0) lat_err++;
            @(negedge clk);
            if (bus.draw_valid !== 1'b0) lat_err++;
            @(negedge clk);
            if (bus.draw_valid !== 1'b1) lat_err++;
            if (bus.draw_card !== 6'(exp_perm[base + d])) card_err++;
        end
        @(negedge clk);
        chk("draw_latency", lat_err, 0);
        chk("draw_cards", card_err, 0);
        chk("draw_count", dv_cnt - v0, n);
    endtask

    initial begin
        int v0, wb, cyc, mism;
        bus.start = 1'b1;
        bus.draw_req = 1'b1;
        bus.seed = 6'd5;
        repeat (3) @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_we", bus.mem_we, 0);
        chk("rst_addr", bus.mem_addr, 0);
        chk("rst_wdata", bus.mem_wdata, 0);
        chk("rst_draw_valid", bus.draw_valid, 0);
        chk("rst_draw_card", bus.draw_card, 0);
        chk("rst_deck_empty", bus.deck_empty, 1);
        chk("rst_no_writes", wa.size(), 0);
        rst = 1'b1;
        bus.start = 1'b0;
        bus.draw_req = 1'b0;
        @(negedge clk);
        v0 = dv_cnt;
        bus.draw_req = 1'b1;
        @(negedge clk);
        bus.draw_req = 1'b0;
        repeat (4) @(negedge clk);
        chk("idle_draw_ignored", dv_cnt - v0, 0);

        run_shuffle(6'b001010, 0);
        for (int k = 0; k < DS; k++) saved[k] = ram[k];
        run_shuffle(6'b001010, 0);
        mism = 0;
        for (int k = 0; k < DS; k++) if (ram[k] !== saved[k]) mism++;
        chk("repeat_same_perm", mism, 0);

        run_shuffle(6'd0, 0);
        for (int k = 0; k < DS; k++) saved[k] = ram[k];
        run_shuffle(6'd1, 0);
        mism = 0;
        for (int k = 0; k < DS; k++) if (ram[k] !== saved[k]) mism++;
        chk("seed0_eq_seed1", mism, 0);

        run_shuffle(6'($urandom_range(1, 63)), 0);
        draw_n(0, DS - 1);
        chk("not_empty_before_last", bus.deck_empty, 0);
        draw_n(DS - 1, 1);
        chk("empty_after_last", bus.deck_empty, 1);
        v0 = dv_cnt;
        bus.draw_req = 1'b1;
        @(negedge clk);
        bus.draw_req = 1'b0;
        repeat (4) @(negedge clk);
        chk("draw_when_empty", dv_cnt - v0, 0);
        chk("still_empty", bus.deck_empty, 1);

        run_shuffle(6'($urandom_range(1, 63)), 0);
        run_shuffle(6'($urandom_range(1, 63)), 1);
        run_shuffle(6'($urandom_range(1, 63)), 2);

        bus.seed = 6'($urandom_range(1, 63));
        wb = wa.size();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 0;
        while (wa.size() - wb < DS + 42 && cyc < 6000) begin
            cyc++;
            @(negedge clk);
        end
        chk("reached_i30", (wa.size() - wb) >= DS + 42, 1);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_we", bus.mem_we, 0);
        chk("midrst_done", bus.done, 0);
        chk("midrst_addr", bus.mem_addr, 0);
        chk("midrst_deck_empty", bus.deck_empty, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_idle_busy", bus.busy, 0);
        run_shuffle(6'($urandom_range(0, 63)), 0);
        draw_n(0, 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/deck_shuffle_ctrl.md
# deck_shuffle_ctrl

Sequencer that owns the single-port deck RAM and shares it between two users: an in-place Fisher-Yates shuffle engine and the game controller's card-draw requests. On `start` it writes the ordered deck (cards 0..51), then shuffles it with a 6-bit LFSR seeded from the switch `seed`, then serves draws sequentially from address 0. It sits between the blackjack game controller and the deck RAM.

## Interface
- `DECK_SIZE`, 52, number of cards; legal range 2..63.
- `IDX_W`, 6, RAM address width and card code width.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `start`  in  1  shuffle request; sampled only in IDLE or READY.
- `seed`  in  6  LFSR seed; sampled on the cycle `start` is accepted.
- `busy`  out  1  high from the cycle after `start` is accepted until the cycle `done` pulses.
- `done`  out  1  one-cycle pulse when the shuffle completes.
- `mem_addr`  out  IDX_W  deck RAM address.
- `mem_we`  out  1  deck RAM write enable.
- `mem_wdata`  out  IDX_W  deck RAM write data.
- `mem_rdata`  in  IDX_W  deck RAM read data; synchronous read with 1-cycle latency.
- `draw_req`  in  1  single-cycle request for the next card.
- `draw_valid`  out  1  one-cycle pulse; `draw_card` is valid.
- `draw_card`  out  IDX_W  drawn card code, 0..DECK_SIZE-1.
- `deck_empty`  out  1  high when no shuffled cards remain to draw.

## Operation
- States: IDLE, INIT, PICK, RD_I, RD_J, CAP_J, WR_I, WR_J, FIN, READY, DRAW.
- IDLE/READY + `start`: load LFSR (`seed`, or 6'b000001 if `seed` == 0), set k = 0, go to INIT.
- INIT: write `mem_addr` = k, `mem_wdata` = k, `mem_we` = 1, for k = 0..DECK_SIZE-1. Then set i = DECK_SIZE-1 and go to PICK.
- PICK: step the LFSR (x^6+x^5+1, Fibonacci form) every cycle. The candidate is r = lfsr-1, giving 0..62. Accept j = r when r <= i, otherwise stay in PICK (rejection sampling). This always terminates within 63 cycles.
- Swap: RD_I reads addr i; RD_J reads addr j and captures a = data(i); CAP_J captures b = data(j); WR_I writes b to i; WR_J writes a to j.
- After the swap, if i == 1 go to FIN; otherwise i--, then PICK. j == i is legal and leaves the RAM unchanged.
- FIN: pulse `done`, clear draw pointer p = 0, clear `deck_empty`, go to READY.
- READY + `draw_req` with p < DECK_SIZE: drive `mem_addr` = p, go to DRAW.
- DRAW: `draw_card` = `mem_rdata`, `draw_valid` = 1, p++, return to READY. Set `deck_empty` when p reaches DECK_SIZE.
- Priority in READY: `start` wins over a simultaneous `draw_req`; the draw is dropped.
- `start` or `draw_req` while busy: ignored, with no queueing.
- `draw_req` while `deck_empty`: no `draw_valid`, no state change.
- `draw_req` in IDLE: ignored.
- `mem_we` is 0 in every state except INIT, WR_I and WR_J.

## Timing
- Reset values: state IDLE, `busy` 0, `done` 0, `mem_we` 0, `mem_addr` 0, `mem_wdata` 0, `draw_valid` 0, `draw_card` 0, `deck_empty` 1, p = 0, LFSR 6'b000001.
- Reset mid-shuffle or mid-draw: the next edge gives reset values. RAM contents are undefined to users; `deck_empty` = 1 until the next `done`.
- Start latency: `start` accepted at edge N, so the first INIT write occurs at edge N+1.
- Shuffle duration: DECK_SIZE init cycles, plus (DECK_SIZE-1) × (5 + PICK cycles), plus 1.
- Draw latency: `draw_req` sampled at edge N gives `draw_valid` at edge N+2. Back-to-back draws are accepted every 2 cycles.
- All outputs are registered.

## Configuration
- `AUTO_RESHUFFLE_EN` defined: a `draw_req` in READY with `deck_empty` = 1 starts a shuffle reusing the current LFSR state (not `seed`). `busy` rises the next cycle, and the pending draw is served automatically after FIN, with `draw_valid` following `done` by 2 cycles.
- `AUTO_RESHUFFLE_EN` undefined: the empty-deck draw is ignored, as described in Operation.

## Structure
- Package `deck_pkg`: DECK_SIZE default, IDX_W, state enum, LFSR tap constant, zero-seed substitute 6'b000001.
- Sub-module `deck_lfsr`: 6-bit LFSR with `load`, `load_val`, `step`, `q`.
- Everything else (FSM, i/j/k/p counters, a/b capture registers) lives in `deck_shuffle_ctrl`.

## Test plan
- Reset with `start` = 1 held → all outputs at reset values, state IDLE, no RAM writes.
- `seed` = 6'b001010, `start` pulse → 52 INIT writes (addr k, data k), `done` pulses once. The RAM then holds a permutation of 0..51, and repeating the run gives an identical permutation.
- `seed` = 0 → behaves exactly like `seed` = 6'b000001 (identical final RAM).
- After `done`, issue 52 draws spaced 3 cycles apart → 52 `draw_valid` pulses matching RAM addresses 0..51 in order. `deck_empty` rises with the 52nd draw; a 53rd `draw_req` gives no `draw_valid` (macro undefined).
- Assert `start` and `draw_req` together in READY → shuffle runs, no `draw_valid`. Pulse `draw_req` while `busy` → ignored.
- Pull `rst` low mid-shuffle (i = 30) → reset values next edge, `deck_empty` = 1. A new `start` completes a full, valid permutation.
